// File: rtl/calc_sched_pkg.sv
// calc_sched_pkg: shared widths, command/response codes and sequencer state for calc_req_sched
package calc_sched_pkg;

    localparam int CALC_CMD_WIDTH  = 4;
    localparam int CALC_DATA_WIDTH = 32;
    localparam int TAG_WIDTH       = 2;
    localparam int NUM_TAGS        = 4;

    localparam logic [CALC_CMD_WIDTH-1:0] CMD_NOP = 4'd0;
    localparam logic [CALC_CMD_WIDTH-1:0] CMD_ADD = 4'd1;
    localparam logic [CALC_CMD_WIDTH-1:0] CMD_SUB = 4'd2;
    localparam logic [CALC_CMD_WIDTH-1:0] CMD_SHL = 4'd5;
    localparam logic [CALC_CMD_WIDTH-1:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_SEND_OP2
    } seq_state_t;

    // Lowest-numbered set bit of a free mask; callers only use it when some bit is set
    function automatic logic [TAG_WIDTH-1:0] lowest_free(input logic [NUM_TAGS-1:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/calc_port_seq.sv
// calc_port_seq: one requester port - two-beat command issue, tag pool and response forwarding
module calc_port_seq
    import calc_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CALC_CMD_WIDTH-1:0]  req_cmd,
    input  logic [CALC_DATA_WIDTH-1:0] req_op1,
    input  logic [CALC_DATA_WIDTH-1:0] req_op2,
    output logic [CALC_CMD_WIDTH-1:0]  dut_cmd,
    output logic [CALC_DATA_WIDTH-1:0] dut_data,
    output logic [TAG_WIDTH-1:0]       dut_tag,
    input  logic [1:0]                 dut_resp,
    input  logic [CALC_DATA_WIDTH-1:0] dut_rdata,
    input  logic [TAG_WIDTH-1:0]       dut_rtag,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_code,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic [CALC_DATA_WIDTH-1:0] rsp_data,
    output logic [2:0]                 outstanding,
    output logic                       err_spurious
);

    seq_state_t                 state, state_nxt;
    logic [NUM_TAGS-1:0]        free_mask, alloc_mask, rel_mask;
    logic [CALC_DATA_WIDTH-1:0] op2_q;
    logic [TAG_WIDTH-1:0]       alloc_tag;
    logic                       live, accept, issue, resp_hit, in_flight;

    // live keeps req_ready low until the first edge after reset is released
    assign req_ready   = live && state == ST_IDLE && |free_mask;
    assign accept      = req_valid && req_ready;
    assign issue       = accept && req_cmd != CMD_NOP;
    assign alloc_tag   = lowest_free(free_mask);
    assign alloc_mask  = issue ? NUM_TAGS'(1) << alloc_tag : '0;
    assign resp_hit    = dut_resp != RESP_NONE;
    assign in_flight   = !free_mask[dut_rtag];
    assign rel_mask    = (resp_hit && in_flight) ? NUM_TAGS'(1) << dut_rtag : '0;
    assign outstanding = 3'($countones(~free_mask));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: an issued command always spends exactly one cycle sending op2
    always_comb begin
        state_nxt = ST_IDLE;
        if (state == ST_IDLE && issue) state_nxt = ST_SEND_OP2;
    end

    // Tag pool, DUT request beats and response forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live         <= 1'b0;
            free_mask    <= '1;
            op2_q        <= '0;
            dut_cmd      <= '0;
            dut_data     <= '0;
            dut_tag      <= '0;
            rsp_valid    <= 1'b0;
            rsp_code     <= '0;
            rsp_tag      <= '0;
            rsp_data     <= '0;
            err_spurious <= 1'b0;
        end else begin
            live         <= 1'b1;
            free_mask    <= (free_mask | rel_mask) & ~alloc_mask;
            if (issue) begin
                dut_cmd  <= req_cmd;
                dut_data <= req_op1;
                dut_tag  <= alloc_tag;
                op2_q    <= req_op2;
            end else if (state == ST_SEND_OP2) begin
                dut_cmd  <= CMD_NOP;
                dut_data <= op2_q;
            end else begin
                dut_cmd  <= CMD_NOP;
                dut_data <= '0;
                dut_tag  <= '0;
            end
            rsp_valid    <= resp_hit;
            rsp_code     <= dut_resp;
            rsp_tag      <= resp_hit ? dut_rtag : '0;
            rsp_data     <= resp_hit ? dut_rdata : '0;
            err_spurious <= err_spurious | (resp_hit && !in_flight);
        end
    end

endmodule

// File: rtl/calc_req_sched.sv
// calc_req_sched: per-port request sequencer between requesters and the calculator DUT
module calc_req_sched
    import calc_sched_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                                 PClk,
    input  logic                                 Rst,
    input  logic [NUM_PORTS-1:0]                 req_valid,
    output logic [NUM_PORTS-1:0]                 req_ready,
    input  logic [NUM_PORTS*CALC_CMD_WIDTH-1:0]  req_cmd,
    input  logic [NUM_PORTS*CALC_DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_PORTS*CALC_DATA_WIDTH-1:0] req_op2,
    output logic [NUM_PORTS*CALC_CMD_WIDTH-1:0]  dut_cmd,
    output logic [NUM_PORTS*CALC_DATA_WIDTH-1:0] dut_data,
    output logic [NUM_PORTS*2-1:0]               dut_tag,
    input  logic [NUM_PORTS*2-1:0]               dut_resp,
    input  logic [NUM_PORTS*CALC_DATA_WIDTH-1:0] dut_rdata,
    input  logic [NUM_PORTS*2-1:0]               dut_rtag,
    output logic [NUM_PORTS-1:0]                 rsp_valid,
    output logic [NUM_PORTS*2-1:0]               rsp_code,
    output logic [NUM_PORTS*2-1:0]               rsp_tag,
    output logic [NUM_PORTS*CALC_DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_PORTS*3-1:0]               outstanding,
    output logic [NUM_PORTS-1:0]                 err_spurious
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc_port_seq u_seq (
            .clk          (PClk),
            .rst_n        (Rst),
            .req_valid    (req_valid[p]),
            .req_ready    (req_ready[p]),
            .req_cmd      (req_cmd[p*CALC_CMD_WIDTH +: CALC_CMD_WIDTH]),
            .req_op1      (req_op1[p*CALC_DATA_WIDTH +: CALC_DATA_WIDTH]),
            .req_op2      (req_op2[p*CALC_DATA_WIDTH +: CALC_DATA_WIDTH]),
            .dut_cmd      (dut_cmd[p*CALC_CMD_WIDTH +: CALC_CMD_WIDTH]),
            .dut_data     (dut_data[p*CALC_DATA_WIDTH +: CALC_DATA_WIDTH]),
            .dut_tag      (dut_tag[p*2 +: 2]),
            .dut_resp     (dut_resp[p*2 +: 2]),
            .dut_rdata    (dut_rdata[p*CALC_DATA_WIDTH +: CALC_DATA_WIDTH]),
            .dut_rtag     (dut_rtag[p*2 +: 2]),
            .rsp_valid    (rsp_valid[p]),
            .rsp_code     (rsp_code[p*2 +: 2]),
            .rsp_tag      (rsp_tag[p*2 +: 2]),
            .rsp_data     (rsp_data[p*CALC_DATA_WIDTH +: CALC_DATA_WIDTH]),
            .outstanding  (outstanding[p*3 +: 3]),
            .err_spurious (err_spurious[p])
        );
    end

endmodule

// File: tb/tb_calc_req_sched.sv
// tb_calc_req_sched: directed checks of issue beats, tag pool, responses and reset
module tb_calc_req_sched;

    logic         PClk = 1'b0;
    logic         Rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  req_cmd;
    logic [127:0] req_op1, req_op2;
    logic [15:0]  dut_cmd;
    logic [127:0] dut_data;
    logic [7:0]   dut_tag;
    logic [7:0]   dut_resp;
    logic [127:0] dut_rdata;
    logic [7:0]   dut_rtag;
    logic [3:0]   rsp_valid;
    logic [7:0]   rsp_code, rsp_tag;
    logic [127:0] rsp_data;
    logic [11:0]  outstanding;
    logic [3:0]   err_spurious;

    int total = 0;
    int bad = 0;

    calc_req_sched dut (
        .PClk         (PClk),
        .Rst          (Rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .dut_cmd      (dut_cmd),
        .dut_data     (dut_data),
        .dut_tag      (dut_tag),
        .dut_resp     (dut_resp),
        .dut_rdata    (dut_rdata),
        .dut_rtag     (dut_rtag),
        .rsp_valid    (rsp_valid),
        .rsp_code     (rsp_code),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data),
        .outstanding  (outstanding),
        .err_spurious (err_spurious)
    );

    always #5 PClk = ~PClk;

    task automatic tick();
        @(posedge PClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[p]       = v;
        req_cmd[p*4 +: 4]  = c;
        req_op1[p*32 +: 32] = a;
        req_op2[p*32 +: 32] = b;
    endtask

    task automatic set_rsp(input int p, input logic [1:0] code, input logic [1:0] tag,
                           input logic [31:0] d);
        dut_resp[p*2 +: 2]    = code;
        dut_rtag[p*2 +: 2]    = tag;
        dut_rdata[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] cmd_of(input int p);
        return 32'(dut_cmd[p*4 +: 4]);
    endfunction
    function automatic logic [31:0] data_of(input int p);
        return dut_data[p*32 +: 32];
    endfunction
    function automatic logic [31:0] tag_of(input int p);
        return 32'(dut_tag[p*2 +: 2]);
    endfunction
    function automatic logic [31:0] outs_of(input int p);
        return 32'(outstanding[p*3 +: 3]);
    endfunction

    initial begin
        Rst = 1'b0;
        req_valid = '0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
        dut_resp = '0; dut_rdata = '0; dut_rtag = '0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_outstanding", 32'(outstanding), 32'h0);
        chk("rst_cmd", 32'(dut_cmd), 32'h0);
        chk("rst_err", 32'(err_spurious), 32'h0);
        Rst = 1'b1;
        chk("ready_before_first_edge", 32'(req_ready), 32'h0);
        tick();
        chk("ready_after_release", 32'(req_ready), 32'hF);

        // port 0: ADD 5 + 7
        set_req(0, 1'b1, 4'd1, 32'd5, 32'd7);
        tick();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("p0_beat1_cmd", cmd_of(0), 32'd1);
        chk("p0_beat1_data", data_of(0), 32'd5);
        chk("p0_beat1_tag", tag_of(0), 32'd0);
        chk("p0_outstanding1", outs_of(0), 32'd1);
        chk("p0_ready_busy", 32'(req_ready[0]), 32'd0);
        tick();
        chk("p0_beat2_cmd", cmd_of(0), 32'd0);
        chk("p0_beat2_data", data_of(0), 32'd7);
        chk("p0_beat2_tag", tag_of(0), 32'd0);
        chk("p0_ready_back", 32'(req_ready[0]), 32'd1);
        set_rsp(0, 2'd1, 2'd0, 32'd12);
        tick();
        set_rsp(0, 2'd0, 2'd0, 32'd0);
        chk("p0_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("p0_rsp_code", 32'(rsp_code[1:0]), 32'd1);
        chk("p0_rsp_data", rsp_data[31:0], 32'd12);
        chk("p0_rsp_tag", 32'(rsp_tag[1:0]), 32'd0);
        chk("p0_outstanding0", outs_of(0), 32'd0);
        chk("p0_idle_data", data_of(0), 32'd0);
        tick();
        chk("p0_rsp_drop", 32'(rsp_valid), 32'h0);

        // all four ports in the same cycle
        set_req(0, 1'b1, 4'd1, 32'd100, 32'd200);
        set_req(1, 1'b1, 4'd2, 32'd101, 32'd201);
        set_req(2, 1'b1, 4'd5, 32'd102, 32'd202);
        set_req(3, 1'b1, 4'd6, 32'd103, 32'd203);
        tick();
        req_valid = '0;
        chk("all_cmd", 32'(dut_cmd), 32'h6521);
        chk("all_tag", 32'(dut_tag), 32'h0);
        chk("all_outstanding", 32'(outstanding), 32'h249);
        for (int p = 0; p < 4; p++) chk("all_op1", data_of(p), 32'(100 + p));
        tick();
        chk("all_cmd_beat2", 32'(dut_cmd), 32'h0);
        for (int p = 0; p < 4; p++) chk("all_op2", data_of(p), 32'(200 + p));
        for (int p = 0; p < 4; p++) set_rsp(p, 2'd1, 2'd0, 32'(300 + p));
        tick();
        dut_resp = '0;
        chk("all_rsp_valid", 32'(rsp_valid), 32'hF);
        for (int p = 0; p < 4; p++) chk("all_rsp_data", rsp_data[p*32 +: 32], 32'(300 + p));
        chk("all_outstanding0", 32'(outstanding), 32'h0);
        chk("all_no_err", 32'(err_spurious), 32'h0);

        // port 1: response for a tag that was never issued
        set_rsp(1, 2'd2, 2'd3, 32'hDEAD);
        tick();
        dut_resp = '0;
        chk("sp_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("sp_rsp_code", 32'(rsp_code[3:2]), 32'd2);
        chk("sp_rsp_tag", 32'(rsp_tag[3:2]), 32'd3);
        chk("sp_rsp_data", rsp_data[63:32], 32'hDEAD);
        chk("sp_err", 32'(err_spurious), 32'h2);
        chk("sp_outstanding", outs_of(1), 32'd0);
        tick();
        chk("sp_err_sticky", 32'(err_spurious), 32'h2);
        chk("sp_rsp_drop", 32'(rsp_valid), 32'h0);

        // port 2: exhaust the tag pool, then recycle tag 1
        for (int i = 0; i < 4; i++) begin
            set_req(2, 1'b1, 4'd1, 32'(10 + i), 32'(20 + i));
            tick();
            chk("p2_tag", tag_of(2), 32'(i));
            chk("p2_op1", data_of(2), 32'(10 + i));
            chk("p2_outstanding", outs_of(2), 32'(i + 1));
            tick();
            chk("p2_op2", data_of(2), 32'(20 + i));
        end
        set_req(2, 1'b1, 4'd2, 32'd50, 32'd60);
        chk("p2_full_ready", 32'(req_ready[2]), 32'd0);
        chk("p2_full_outstanding", outs_of(2), 32'd4);
        tick();
        chk("p2_blocked_cmd", cmd_of(2), 32'd0);
        chk("p2_blocked_outstanding", outs_of(2), 32'd4);
        set_rsp(2, 2'd1, 2'd1, 32'd77);
        tick();
        dut_resp = '0;
        chk("p2_free_rsp_tag", 32'(rsp_tag[5:4]), 32'd1);
        chk("p2_free_outstanding", outs_of(2), 32'd3);
        chk("p2_free_ready", 32'(req_ready[2]), 32'd1);
        chk("p2_free_no_issue", cmd_of(2), 32'd0);
        tick();
        req_valid[2] = 1'b0;
        chk("p2_reuse_tag", tag_of(2), 32'd1);
        chk("p2_reuse_cmd", cmd_of(2), 32'd2);
        chk("p2_reuse_outstanding", outs_of(2), 32'd4);
        tick();

        // port 3: NOP handshake consumes nothing
        set_req(3, 1'b1, 4'd0, 32'd9, 32'd9);
        chk("p3_nop_ready", 32'(req_ready[3]), 32'd1);
        tick();
        req_valid[3] = 1'b0;
        chk("p3_nop_cmd", cmd_of(3), 32'd0);
        chk("p3_nop_outstanding", outs_of(3), 32'd0);
        chk("p3_nop_ready_after", 32'(req_ready[3]), 32'd1);
        set_req(3, 1'b1, 4'd2, 32'd40, 32'd41);
        tick();
        req_valid[3] = 1'b0;
        chk("p3_first_tag", tag_of(3), 32'd0);
        chk("p3_outstanding1", outs_of(3), 32'd1);

        // reset while port 3 is sending op2
        Rst = 1'b0;
        #1;
        chk("mid_rst_cmd", 32'(dut_cmd), 32'h0);
        chk("mid_rst_data", data_of(3), 32'h0);
        chk("mid_rst_outstanding", 32'(outstanding), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_err", 32'(err_spurious), 32'h0);
        tick();
        Rst = 1'b1;
        tick();
        set_rsp(3, 2'd1, 2'd0, 32'd81);
        tick();
        dut_resp = '0;
        chk("late_rsp_valid", 32'(rsp_valid), 32'h8);
        chk("late_err", 32'(err_spurious), 32'h8);
        chk("late_outstanding", 32'(outstanding), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_req_sched.md
# calc_req_sched

Request sequencer sitting between four upstream requesters and the four command ports of the calculator DUT. Each requester owns one DUT port; the block converts a single-beat request (command, two operands) into the DUT's two-cycle command/operand protocol, allocates 2-bit tags from a per-port pool, and routes DUT responses back with tag bookkeeping. It is the only driver of the DUT request ports and the only consumer of its response ports.

## Interface
- CALC_CMD_WIDTH, 4, command field width
- CALC_DATA_WIDTH, 32, operand/result width
- NUM_PORTS, 4, requester/DUT port count
- PClk  in  1  clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- req_valid  in  NUM_PORTS  request present, per port
- req_ready  out  NUM_PORTS  request accepted this cycle when valid&ready
- req_cmd  in  NUM_PORTS*CALC_CMD_WIDTH  command, port p at slice p
- req_op1, req_op2  in  NUM_PORTS*CALC_DATA_WIDTH  operands
- dut_cmd  out  NUM_PORTS*CALC_CMD_WIDTH  to DUT reqN_cmd_in
- dut_data  out  NUM_PORTS*CALC_DATA_WIDTH  to DUT reqN_data_in
- dut_tag  out  NUM_PORTS*2  to DUT reqN_tag_in
- dut_resp  in  NUM_PORTS*2  DUT out_respN (0 = none, 1 ok, 2 overflow/invalid, 3 reserved)
- dut_rdata  in  NUM_PORTS*CALC_DATA_WIDTH  DUT out_dataN
- dut_rtag  in  NUM_PORTS*2  DUT out_tagN
- rsp_valid  out  NUM_PORTS  response strobe, one cycle, no backpressure
- rsp_code, rsp_tag  out  NUM_PORTS*2  forwarded response code, tag
- rsp_data  out  NUM_PORTS*CALC_DATA_WIDTH  forwarded result
- outstanding  out  NUM_PORTS*3  tags in flight per port (0..4)
- err_spurious  out  NUM_PORTS  sticky: response with tag not in flight

## Operation
- Per port, independent FSM: IDLE, SEND_OP2.
- req_ready[p] = state IDLE and at least one free tag; combinational from registered state.
- Accept in IDLE with cmd != 0: allocate lowest-numbered free tag, drive cmd/op1/tag, go SEND_OP2. Next cycle drive cmd=0, data=op2, tag held; return to IDLE.
- Accept with cmd == 0: handshake completes, nothing issued, no tag consumed, no response generated.
- Command codes otherwise not checked; DUT reports invalid codes.
- Response: dut_resp[p] != 0 sampled at edge -> rsp_valid/code/data/tag registered for one cycle; tag returned to pool if in flight, else err_spurious[p] set and pool unchanged.
- Tag freed and allocated same edge: freed tag usable from next cycle only.
- IDLE with no accept: dut_cmd = 0, dut_data = 0, dut_tag = 0.
- err_spurious cleared only by reset.

## Timing
- Reset (async assert): all outputs 0, all tags free, FSMs IDLE, err_spurious 0; req_ready rises first cycle after deassertion.
- Accept at edge k: cmd/op1/tag valid after k; op2 after k+1; req_ready low during SEND_OP2. Peak throughput one request per 2 cycles per port.
- Response latency: DUT response at edge k -> rsp_valid high after k, low after k+1 unless another response.
- outstanding updates on the same edge as allocate/free; simultaneous alloc+free leaves count unchanged.
- Reset mid-operation: in-flight tags discarded; post-reset DUT responses for them set err_spurious.

## Structure
- Package calc_sched_pkg: CALC_CMD_WIDTH, CALC_DATA_WIDTH, command codes (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), resp codes, state enum.
- Sub-module calc_port_seq: one port's FSM, 4-bit tag free mask, lowest-free priority encoder, response register; top instantiates NUM_PORTS copies via generate.

## Test plan
- Port 0 ADD op1=5 op2=7: cycle after accept dut_cmd=1, dut_data=5, dut_tag=0; next dut_cmd=0, dut_data=7; DUT resp 1 data 12 tag 0 -> rsp_valid one cycle, code 1, data 12, outstanding 1->0.
- Five back-to-back requests on port 2 with no responses: tags 0,1,2,3 issued, req_ready low after fourth, outstanding=4; response tag 1 -> next request gets tag 1.
- All four ports request same cycle: all accepted together, independent tags, no cross-port interference.
- Response tag 3 on port 1 with nothing in flight -> rsp forwarded, err_spurious[1]=1, outstanding stays 0.
- req_cmd=0 on port 3 -> ready handshake, dut_cmd stays 0, no tag used.
- Rst low during SEND_OP2 -> outputs 0 immediately, outstanding 0; late DUT response sets err_spurious.
